// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receive front end: sync, deglitch, 11-bit frame deserialise, F0/E0 prefix strip.
// Optional odd-parity qualification is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_scancode_rx #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] scanCode,
  output logic       isBreak,
  output logic       isExt,
  output logic       codeValid,
  output logic       frameErr
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [1:0]     clk_sync;
  logic [1:0]     data_sync;
  logic [FCW-1:0] fcnt;
  logic           filt;
  logic           filt_q;
  logic           bit_evt_c;
  logic           data_bit_c;
  logic           frame_ok_c;

  state_t         state;
  logic [2:0]     bcnt;
  logic [7:0]     shreg;
  logic [TCW-1:0] tcnt;
  logic           brk_pend;
  logic           ext_pend;

  // Two-flop synchronisers; idle bus level is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2Clk};
      data_sync <= {data_sync[0], ps2Data};
    end
  end

  // Saturating deglitch filter: level flips only once the opposite level has persisted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt   <= '0;
      filt   <= 1'b1;
      filt_q <= 1'b1;
    end else begin
      filt_q <= filt;
      if (clk_sync[1] == filt) begin
        fcnt <= '0;
      end else if (fcnt == FCW'(FILTER_LEN)) begin
        filt <= clk_sync[1];
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + FCW'(1);
      end
    end
  end

  assign bit_evt_c  = filt_q & ~filt;
  assign data_bit_c = data_sync[1];

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  assign frame_ok_c = data_bit_c & (^{shreg, par_bit});
`else
  assign frame_ok_c = data_bit_c;
`endif

  // Frame FSM, timeout supervision and prefix tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bcnt      <= '0;
      shreg     <= '0;
      tcnt      <= '0;
      brk_pend  <= 1'b0;
      ext_pend  <= 1'b0;
      scanCode  <= '0;
      isBreak   <= 1'b0;
      isExt     <= 1'b0;
      codeValid <= 1'b0;
      frameErr  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      codeValid <= 1'b0;
      frameErr  <= 1'b0;
      if (state == S_IDLE) begin
        tcnt <= '0;
        if (bit_evt_c && !data_bit_c) begin
          state <= S_DATA;
          bcnt  <= '0;
        end
      end else if (bit_evt_c) begin
        tcnt <= '0;
        case (state)
          S_DATA: begin
            shreg <= {data_bit_c, shreg[7:1]};
            bcnt  <= bcnt + 3'd1;
            if (bcnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= data_bit_c;
`endif
            state <= S_STOP;
          end
          default: begin
            state <= S_IDLE;
            if (!frame_ok_c) begin
              frameErr <= 1'b1;
              brk_pend <= 1'b0;
              ext_pend <= 1'b0;
            end else if (shreg == BRK_CODE) begin
              brk_pend <= 1'b1;
            end else if (shreg == EXT_CODE) begin
              ext_pend <= 1'b1;
            end else begin
              scanCode  <= shreg;
              isBreak   <= brk_pend;
              isExt     <= ext_pend;
              codeValid <= 1'b1;
              brk_pend  <= 1'b0;
              ext_pend  <= 1'b0;
            end
          end
        endcase
      end else if (tcnt == TCW'(TIMEOUT - 1)) begin
        // Device stopped clocking mid-frame: abandon it
        state    <= S_IDLE;
        tcnt     <= '0;
        frameErr <= 1'b1;
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
      end else begin
        tcnt <= tcnt + TCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed self-checking bench for ps2_scancode_rx (default parameters).
// Expectations follow PS2_PARITY_CHECK_EN when the macro is defined for the build.
module tb_ps2_scancode_rx;

  localparam int unsigned FILTER_LEN = 8;
  localparam int unsigned TIMEOUT    = 50000;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] scanCode;
  logic       isBreak;
  logic       isExt;
  logic       codeValid;
  logic       frameErr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int last_cv_cyc = 0;
  int last_fe_cyc = 0;
  int last_fall_cyc = 0;
  int cv0;
  int fe0;

  ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .ps2Clk(ps2Clk),
    .ps2Data(ps2Data),
    .scanCode(scanCode),
    .isBreak(isBreak),
    .isExt(isExt),
    .codeValid(codeValid),
    .frameErr(frameErr)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  // Strobe monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (codeValid) begin
      cv_cnt++;
      last_cv_cyc = cyc;
    end
    if (frameErr) begin
      fe_cnt++;
      last_fe_cyc = cyc;
    end
    if (codeValid && frameErr) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  // One PS/2 bit: 10 cycles setup, 20 low, 10 high (optional 5-cycle low glitch while high)
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2Data = b;
    repeat (10) @(negedge clk);
    ps2Clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (20) @(negedge clk);
    ps2Clk = 1'b1;
    if (glitch) begin
      repeat (5) @(negedge clk);
      ps2Clk = 1'b0;
      repeat (5) @(negedge clk);
      ps2Clk = 1'b1;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits, input int glitch_after);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], i == glitch_after);
    ps2Data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, odd_par(d), 1'b1, 11, -1);
  endtask

  initial begin
    rst = 1'b1;
    ps2Clk = 1'b1;
    ps2Data = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_scancode", 32'(scanCode), 32'h0);
    check("rst_isbreak", 32'(isBreak), 32'h0);
    check("rst_isext", 32'(isExt), 32'h0);
    check("rst_codevalid", 32'(codeValid), 32'h0);
    check("rst_frameerr", 32'(frameErr), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Idle glitch with data low: would look like a start bit if it got through
    ps2Data = 1'b0;
    ps2Clk = 1'b0;
    repeat (5) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (10) @(negedge clk);
    ps2Data = 1'b1;
    repeat (20) @(negedge clk);

    // Plain make code
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_byte(8'h1D);
    check("1d_cv", 32'(cv_cnt - cv0), 32'd1);
    check("1d_code", 32'(scanCode), 32'h1D);
    check("1d_brk", 32'(isBreak), 32'h0);
    check("1d_ext", 32'(isExt), 32'h0);
    check("1d_fe", 32'(fe_cnt - fe0), 32'd0);
    check("1d_latency", 32'(last_cv_cyc - last_fall_cyc), 32'(FILTER_LEN + 4));

    // Break prefix then code, then a plain code
    cv0 = cv_cnt;
    send_byte(8'hF0);
    check("f0_no_cv", 32'(cv_cnt - cv0), 32'd0);
    send_byte(8'h1B);
    check("brk_cv", 32'(cv_cnt - cv0), 32'd1);
    check("brk_code", 32'(scanCode), 32'h1B);
    check("brk_flag", 32'(isBreak), 32'h1);
    send_byte(8'h44);
    check("44_code", 32'(scanCode), 32'h44);
    check("44_brk", 32'(isBreak), 32'h0);

    // Extended break
    cv0 = cv_cnt;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h7C);
    check("ext_cv", 32'(cv_cnt - cv0), 32'd1);
    check("ext_code", 32'(scanCode), 32'h7C);
    check("ext_brk", 32'(isBreak), 32'h1);
    check("ext_ext", 32'(isExt), 32'h1);

    // Wrong parity
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h7D, 1'b0, 1'b1, 11, -1);
`ifdef PS2_PARITY_CHECK_EN
    check("par_fe", 32'(fe_cnt - fe0), 32'd1);
    check("par_cv", 32'(cv_cnt - cv0), 32'd0);
    check("par_code", 32'(scanCode), 32'h7C);
`else
    check("par_fe", 32'(fe_cnt - fe0), 32'd0);
    check("par_cv", 32'(cv_cnt - cv0), 32'd1);
    check("par_code", 32'(scanCode), 32'h7D);
`endif

    // Bad stop bit after a break prefix clears the pending break
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_byte(8'hF0);
    send_frame(8'h22, odd_par(8'h22), 1'b0, 11, -1);
    check("stop_fe", 32'(fe_cnt - fe0), 32'd1);
    check("stop_cv", 32'(cv_cnt - cv0), 32'd0);
    send_byte(8'h33);
    check("after_bad_code", 32'(scanCode), 32'h33);
    check("after_bad_brk", 32'(isBreak), 32'h0);

    // Glitch between bits of a frame
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h1B, odd_par(8'h1B), 1'b1, 11, 3);
    check("glitch_cv", 32'(cv_cnt - cv0), 32'd1);
    check("glitch_code", 32'(scanCode), 32'h1B);
    check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);

    // Timeout: start + 4 data bits then silence
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h4B, 1'b1, 1'b1, 5, -1);
    for (int i = 0; i < TIMEOUT + 2000 && fe_cnt == fe0; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    check("to_fe", 32'(fe_cnt - fe0), 32'd1);
    check("to_latency", 32'(last_fe_cyc - last_fall_cyc), 32'(FILTER_LEN + 4 + TIMEOUT));
    check("to_cv", 32'(cv_cnt - cv0), 32'd0);
    send_byte(8'h4B);
    check("to_next_code", 32'(scanCode), 32'h4B);
    check("to_next_cv", 32'(cv_cnt - cv0), 32'd1);

    // Mid-frame reset with non-zero outputs beforehand
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h71);
    check("pre_rst_code", 32'(scanCode), 32'h71);
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h44, 1'b1, 1'b1, 5, -1);
    rst = 1'b1;
    #1;
    check("mrst_code", 32'(scanCode), 32'h0);
    check("mrst_brk", 32'(isBreak), 32'h0);
    check("mrst_ext", 32'(isExt), 32'h0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("mrst_no_strobe", 32'((cv_cnt - cv0) + (fe_cnt - fe0)), 32'd0);
    send_byte(8'h44);
    check("mrst_next_cv", 32'(cv_cnt - cv0), 32'd1);
    check("mrst_next_code", 32'(scanCode), 32'h44);
    check("mrst_next_fe", 32'(fe_cnt - fe0), 32'd0);

    check("no_overlap", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

PS/2 keyboard receive front end feeding `paddleController`'s key decoder. It synchronises and deglitches the raw `ps2Clk`/`ps2Data` lines and deserialises 11-bit device-to-host frames. It strips the 0xF0 break and 0xE0 extended prefixes and presents one qualified scan code per key event as a single-cycle strobe. Framing, parity and timeout faults are reported on a separate error strobe.

## Interface
- `FILTER_LEN`, 8: consecutive identical `clk` samples required before the filtered PS/2 clock changes level (valid range 2–255).
- `TIMEOUT`, 50000: `clk` cycles without a filtered falling edge before an in-progress frame is abandoned (1 ms at 50 MHz).
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `ps2Clk` in 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2Data` in 1: raw PS/2 data, asynchronous to `clk`.
- `scanCode` out 8: last accepted code byte, prefixes excluded.
- `isBreak` out 1: `scanCode` was preceded by 0xF0.
- `isExt` out 1: `scanCode` was preceded by 0xE0.
- `codeValid` out 1: one-cycle strobe; `scanCode`, `isBreak` and `isExt` are updated in the same cycle.
- `frameErr` out 1: one-cycle strobe on a rejected frame.

## Operation
- Both inputs pass through 2-flop synchronisers.
- The synced `ps2Clk` feeds a saturating filter counter. The filtered level flips only after `FILTER_LEN` consecutive samples opposite to the current level.
- A filtered 1→0 transition is the bit event. Synced `ps2Data` is sampled in that same cycle.
- FSM states are IDLE, DATA, PARITY and STOP.
  - IDLE: on a bit event with data=0, go to DATA with bit count cleared. With data=1 the event is ignored.
  - DATA: shift the bit in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: latch the bit and go to STOP.
  - STOP: on a bit event, the frame is good when stop=1 and the parity check passes; otherwise it is bad. Return to IDLE either way.
- Good frame handling:
  - Byte 0xF0 sets `brkPend`.
  - Byte 0xE0 sets `extPend`.
  - Any other byte loads `scanCode`, `isBreak`=`brkPend` and `isExt`=`extPend`, pulses `codeValid`, and clears both pend flags.
  - Prefix bytes never pulse `codeValid`.
- Bad frame: pulse `frameErr`, clear both pend flags, and do not update `scanCode`.
- Timeout counter:
  - Cleared on every bit event and held at 0 in IDLE.
  - When it reaches `TIMEOUT` in any other state: go to IDLE, pulse `frameErr`, clear both pend flags.
- Reset values: all outputs 0, FSM IDLE, filtered clock 1, pend flags 0, counters 0.
- `scanCode`, `isBreak` and `isExt` hold their values between strobes.

## Timing
- From the first `clk` edge that samples raw `ps2Clk` low, the filtered fall occurs `2+FILTER_LEN` cycles later. A qualifying stop-bit fall raises `codeValid` on the following cycle, `3+FILTER_LEN` cycles in total (11 at the default).
- `codeValid` and `frameErr` are never high in the same cycle, and each is high for exactly one cycle.
- A `ps2Clk` low pulse shorter than `FILTER_LEN` cycles produces no bit event in any state.
- Asserting `rst` mid-frame takes effect immediately: the partial frame is lost and no strobe is emitted. The next frame after release is received normally.
- A start bit arriving in the same cycle as a timeout expiry is not possible, because the timeout is not armed in IDLE.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: a frame is good only if data bits plus the parity bit contain an odd number of ones. A mismatch gives `frameErr`.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is clocked through but ignored, and only the stop bit qualifies the frame. No parity logic is synthesised.

## Test plan
All stimulus uses a 100 µs PS/2 bit period, with data changed 5 µs before each `ps2Clk` fall and default parameters.

- Frame 0x1D with parity 1 and stop 1 → exactly one `codeValid`; `scanCode`=0x1D, `isBreak`=0, `isExt`=0; `frameErr` never asserts.
- Frames 0xF0 then 0x1B → a single `codeValid` after the second frame, with `scanCode`=0x1B and `isBreak`=1. A following 0x44 → `scanCode`=0x44, `isBreak`=0.
- Frame 0x7D with parity 0:
  - With `PS2_PARITY_CHECK_EN` → one `frameErr` pulse, no `codeValid`, `scanCode` unchanged.
  - Without it → `codeValid` with `scanCode`=0x7D.
- Start bit plus 4 data bits, then `ps2Clk` held high for 1.5 ms → one `frameErr` exactly 50000 cycles after the last bit event. A subsequent full 0x4B frame → `codeValid`, `scanCode`=0x4B.
- 100 ns (5-cycle) low glitch on `ps2Clk`, both in IDLE and between bits of a 0x1B frame → no spurious bit event; the frame still decodes as 0x1B.
- `rst` asserted for 100 ns after the 5th bit of a frame → all outputs 0 immediately. The next 0x44 frame → `codeValid`, `scanCode`=0x44.
